// File: rtl/ls_pilot_estimator.sv
// rtl/ls_pilot_estimator.sv - LS NRS pilot estimator: de-rotates four pilots per window and holds E1..E4 under valid/ready
module ls_pilot_estimator #(
    parameter  int IN_WIDTH  = 16,
    localparam int OUT_WIDTH = IN_WIDTH + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        pilot_valid,
    output logic                        pilot_ready,
    input  logic signed [IN_WIDTH-1:0]  pilot_r,
    input  logic signed [IN_WIDTH-1:0]  pilot_i,
    input  logic [1:0]                  nrs_bits,
    output logic [1:0]                  pilot_idx,
    output logic                        est_valid,
    input  logic                        est_ready,
    output logic signed [OUT_WIDTH-1:0] E1_r,
    output logic signed [OUT_WIDTH-1:0] E2_r,
    output logic signed [OUT_WIDTH-1:0] E3_r,
    output logic signed [OUT_WIDTH-1:0] E4_r,
    output logic signed [OUT_WIDTH-1:0] E1_i,
    output logic signed [OUT_WIDTH-1:0] E2_i,
    output logic signed [OUT_WIDTH-1:0] E3_i,
    output logic signed [OUT_WIDTH-1:0] E4_i
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                      state;
    logic signed [OUT_WIDTH-1:0] e_r [4];
    logic signed [OUT_WIDTH-1:0] e_i [4];

    logic signed [OUT_WIDTH-1:0] s_r, s_i;
    logic signed [OUT_WIDTH-1:0] a_r, a_i, b_r, b_i;
    logic signed [OUT_WIDTH-1:0] der_r, der_i;
    logic                        accept;

    // Multiplying by a QPSK reference of +/-1 is a conditional negate on the widened operand.
    assign s_r   = {pilot_r[IN_WIDTH-1], pilot_r};
    assign s_i   = {pilot_i[IN_WIDTH-1], pilot_i};
    assign a_r   = nrs_bits[0] ? -s_r : s_r;
    assign a_i   = nrs_bits[0] ? -s_i : s_i;
    assign b_r   = nrs_bits[1] ? -s_r : s_r;
    assign b_i   = nrs_bits[1] ? -s_i : s_i;
    assign der_r = a_r + b_i;
    assign der_i = a_i - b_r;

    assign pilot_ready = (state == COLLECT) || ((state == HOLD) && est_ready);
    assign accept      = pilot_valid && pilot_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= COLLECT;
            est_valid <= 1'b0;
            pilot_idx <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                e_r[k] <= '0;
                e_i[k] <= '0;
            end
        end else if (flush) begin
            state     <= COLLECT;
            est_valid <= 1'b0;
            pilot_idx <= 2'd0;
        end else begin
            if ((state == HOLD) && est_ready) begin
                state     <= COLLECT;
                est_valid <= 1'b0;
            end
            // A pilot accepted on the handshake edge opens the next window with no bubble.
            if (accept) begin
                e_r[pilot_idx] <= der_r;
                e_i[pilot_idx] <= der_i;
                pilot_idx      <= pilot_idx + 2'd1;
                if (pilot_idx == 2'd3) begin
                    state     <= HOLD;
                    est_valid <= 1'b1;
                end
            end
        end
    end

    assign E1_r = e_r[0];
    assign E2_r = e_r[1];
    assign E3_r = e_r[2];
    assign E4_r = e_r[3];
    assign E1_i = e_i[0];
    assign E2_i = e_i[1];
    assign E3_i = e_i[2];
    assign E4_i = e_i[3];

endmodule
